// File: rtl/wb_sel_pkg.sv
// Shared definitions for the write-back source selector: source indices,
// the built-in constant, the buffered entry type and the skid occupancy states.
package wb_sel_pkg;
  localparam int SRC_ALUOUT   = 0;
  localparam int SRC_LSCTRL   = 1;
  localparam int SRC_IMM_SL16 = 2;
  localparam int SRC_HI       = 3;
  localparam int SRC_LO       = 4;
  localparam int SRC_CONST227 = 5;
  localparam int SRC_IMM_SEXT = 6;
  localparam int SRC_SHIFT    = 7;
  localparam int SRC_B        = 8;
  localparam int SRC_A        = 9;
  localparam int SRC_LT       = 10;
  localparam int WB_N_SRC     = 11;

  localparam int WB_CONST_VAL = 227;
  localparam int WB_DATA_W    = 32;
  localparam int WB_REG_AW    = 5;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_REG_AW-1:0] dst;
    logic                 we;
  } wb_entry_t;

  typedef enum logic [1:0] {CNT_EMPTY, CNT_ONE, CNT_FULL} cnt_e;
endpackage

// File: rtl/wb_skid2.sv
// Generic 2-entry valid/ready skid buffer; in_ready is registered so the
// downstream ready never reaches the upstream combinationally.
// With WB_SEL_FWD_EN defined the skid entry is exported for forwarding.
module wb_skid2 import wb_sel_pkg::*; #(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  entry_t in_entry,
  input  logic   in_valid,
  output logic   in_ready,
  output entry_t out_entry,
  output logic   out_valid,
  input  logic   out_ready
`ifdef WB_SEL_FWD_EN
  ,
  output entry_t skid_entry,
  output logic   skid_valid
`endif
);
  cnt_e   state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   rdy_q;
  logic   in_xfer, out_xfer;

  assign out_valid = (state_q != CNT_EMPTY);
  assign out_entry = main_q;
  assign in_ready  = rdy_q;
  assign in_xfer   = in_valid && rdy_q;
  assign out_xfer  = out_valid && out_ready;

`ifdef WB_SEL_FWD_EN
  assign skid_entry = skid_q;
  assign skid_valid = (state_q == CNT_FULL);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CNT_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != CNT_FULL);
    end
  end

  // main always holds the oldest entry; skid only fills when main is stalled
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      CNT_EMPTY: if (in_xfer) begin
        main_d  = in_entry;
        state_d = CNT_ONE;
      end
      CNT_ONE: begin
        if (in_xfer && out_xfer) main_d = in_entry;
        else if (in_xfer) begin
          skid_d  = in_entry;
          state_d = CNT_FULL;
        end else if (out_xfer) state_d = CNT_EMPTY;
      end
      CNT_FULL: if (out_xfer) begin
        main_d  = skid_q;
        state_d = CNT_ONE;
      end
      default: state_d = CNT_EMPTY;
    endcase
  end
endmodule

// File: rtl/wb_sel_pipe.sv
// Register-file write-back selector: picks one of N_SRC sources, qualifies the
// write-enable and hands the entry to a 2-entry skid buffer. WB_SEL_FWD_EN adds a forwarding lookup.
module wb_sel_pipe import wb_sel_pkg::*; #(
  parameter int DATA_W    = WB_DATA_W,
  parameter int N_SRC     = WB_N_SRC,
  parameter int SEL_W     = $clog2(N_SRC),
  parameter int REG_AW    = WB_REG_AW,
  parameter int CONST_IDX = SRC_CONST227,
  parameter int CONST_VAL = WB_CONST_VAL
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_SRC*DATA_W-1:0] src_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic [REG_AW-1:0]       in_dst,
  input  logic                    in_we,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [REG_AW-1:0]       out_dst,
  output logic                    out_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    clr_err
`ifdef WB_SEL_FWD_EN
  ,
  input  logic [REG_AW-1:0]       fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dst;
    logic              we;
  } entry_t;

  entry_t in_e, out_e;
  logic   sel_legal;

  // illegal selects forward zero data with we cleared so completion is still signalled
  always_comb begin
    in_e      = '0;
    sel_legal = (32'(sel) < N_SRC);
    for (int i = 0; i < N_SRC; i++)
      if (32'(sel) == i)
        in_e.data = (i == CONST_IDX) ? DATA_W'(CONST_VAL) : src_bus[i*DATA_W +: DATA_W];
    in_e.dst = in_dst;
    in_e.we  = in_we && (in_dst != '0) && sel_legal;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                          sel_err <= 1'b0;
    else if (in_valid && in_ready && !sel_legal) sel_err <= 1'b1;
    else if (clr_err)                      sel_err <= 1'b0;
  end

`ifdef WB_SEL_FWD_EN
  entry_t skid_e;
  logic   skid_v, main_hit, skid_hit;
`endif

  wb_skid2 #(.entry_t(entry_t)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_entry  (in_e),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_entry (out_e),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef WB_SEL_FWD_EN
    ,
    .skid_entry(skid_e),
    .skid_valid(skid_v)
`endif
  );

  assign out_data = out_e.data;
  assign out_dst  = out_e.dst;
  assign out_we   = out_e.we;

`ifdef WB_SEL_FWD_EN
  // the skid entry is younger, so it shadows a matching main entry
  always_comb begin
    skid_hit = skid_v && skid_e.we && (skid_e.dst == fwd_addr) && (fwd_addr != '0);
    main_hit = out_valid && out_e.we && (out_e.dst == fwd_addr) && (fwd_addr != '0);
    fwd_hit  = skid_hit || main_hit;
    fwd_data = skid_hit ? skid_e.data : (main_hit ? out_e.data : '0);
  end
`endif
endmodule
